// File: rtl/seg_scan_ctrl.sv
// Purpose : time-multiplexed hex driver for NDIG common-anode 7-segment digits with
//           double-buffered contents, leading-zero blanking and PWM brightness.
// Latency : an/seg/dp_n are registered, one cycle behind the scan position (idx, cnt).
// Backpr. : none; load is a strobe that is remembered until the next frame wrap.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   data       NDIG hex nibbles, nibble i drives digit i (digit 0 rightmost)
//   dp         per-digit decimal point request, 1 = lit
//   dig_en     per-digit enable, 0 = digit dark
//   blank_lz   1 = blank leading zero digits
//   bright     brightness, 0 = dimmest nonzero duty, all-ones = full on
//   load       single-cycle request to refresh the shadow copy at the next frame wrap
//   an         anode select, active-low, one-hot-low when a digit is lit
//   seg        segments {a,b,c,d,e,f,g}, active-low
//   dp_n       decimal point, active-low
//   frame_done one-cycle pulse in the cycle after the digit index wraps
module seg_scan_ctrl #(
   parameter int NDIG  = 8,
   parameter int DIV   = 16,
   parameter int PWM_W = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4*NDIG-1:0]   data,
   input  logic [NDIG-1:0]     dp,
   input  logic [NDIG-1:0]     dig_en,
   input  logic                blank_lz,
   input  logic [PWM_W-1:0]    bright,
   input  logic                load,
   output logic [NDIG-1:0]     an,
   output logic [6:0]          seg,
   output logic                dp_n,
   output logic                frame_done
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int PW = PWM_W + CW + 1;
   localparam int SL = DIV >> PWM_W;

   // scan position
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              pending_q, pending_d;

   // shadow copy of the display contents
   logic [4*NDIG-1:0] data_q, data_d;
   logic [NDIG-1:0]   dp_q, dp_d;
   logic [NDIG-1:0]   en_q, en_d;
   logic              blz_q, blz_d;

   // registered pin drivers
   logic [NDIG-1:0]   an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic              dpn_q, dpn_d;
   logic              fd_q, fd_d;

   logic              tick, wrap, capture;
   logic [NDIG-1:0]   lz_blank;
   logic              zero_run;
   logic [3:0]        nib;
   logic [PW-1:0]     thr;
   logic              pwm_on, dark;

   function automatic logic [6:0] decode(input logic [3:0] n);
      logic [6:0] s;
      s = 7'h7F;
      case (n)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         4'hF: s = 7'b0111000;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // Scan counters and shadow update. The shadow only changes on the wrap tick,
   // so a frame is always drawn from one consistent snapshot.
   always_comb begin
      tick      = (cnt_q == CW'(DIV - 1));
      wrap      = tick && (idx_q == IW'(NDIG - 1));
      capture   = wrap && (pending_q || load);

      cnt_d     = tick ? '0 : cnt_q + CW'(1);
      idx_d     = idx_q;
      if (tick) begin
         idx_d = wrap ? '0 : idx_q + IW'(1);
      end

      // A load landing on the wrap tick is consumed by that same capture.
      pending_d = wrap ? 1'b0 : (pending_q | load);

      data_d    = data_q;
      dp_d      = dp_q;
      en_d      = en_q;
      blz_d     = blz_q;
      if (capture) begin
         data_d = data;
         dp_d   = dp;
         en_d   = dig_en;
         blz_d  = blank_lz;
      end
   end

   // Leading-zero mask: walk from the most significant digit down while every
   // nibble seen so far is zero. Digit 0 is always kept so zero reads as "0".
   always_comb begin
      zero_run = 1'b1;
      lz_blank = '0;
      for (int k = NDIG - 1; k >= 0; k--) begin
         zero_run    = zero_run & (data_q[4*k +: 4] == 4'h0);
         lz_blank[k] = blz_q & zero_run & (k != 0);
      end
   end

   // Pixel for the current scan position, registered into the pin drivers.
   always_comb begin
      nib    = data_q[{idx_q, 2'b00} +: 4];
      // Widened so (bright+1)*SL can equal DIV without wrapping.
      thr    = (PW'(bright) + PW'(1)) * PW'(SL);
      pwm_on = (PW'(cnt_q) < thr);
      dark   = !en_q[idx_q] || lz_blank[idx_q] || !pwm_on;

      an_d   = '1;
      seg_d  = 7'h7F;
      dpn_d  = 1'b1;
      fd_d   = wrap;
      if (!dark) begin
         an_d  = ~({{(NDIG-1){1'b0}}, 1'b1} << idx_q);
         seg_d = decode(nib);
         dpn_d = ~dp_q[idx_q];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         idx_q     <= '0;
         pending_q <= 1'b0;
         data_q    <= '0;
         dp_q      <= '0;
         en_q      <= '0;
         blz_q     <= 1'b0;
         an_q      <= '1;
         seg_q     <= 7'h7F;
         dpn_q     <= 1'b1;
         fd_q      <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         data_q    <= data_d;
         dp_q      <= dp_d;
         en_q      <= en_d;
         blz_q     <= blz_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dpn_q     <= dpn_d;
         fd_q      <= fd_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp_n       = dpn_q;
   assign frame_done = fd_q;

endmodule
